// File: rtl/acc_pkg.sv
// Shared sizing for the adder FSM and its datapath so both agree on the
// address width, plus a saturating increment used by the load counter.
package acc_pkg;

    localparam int ACC_DATA_W = 8;
    localparam int ACC_ADDR_W = 5;
    localparam int ACC_DEPTH  = 2 ** ACC_ADDR_W;

    function automatic logic [ACC_ADDR_W:0] sat_inc(input logic [ACC_ADDR_W:0] val);
        return (val == '1) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/acc_datapath_ram_sync.sv
// Single-write-port synchronous RAM with a registered, read-first output.
// The output register holds its word while re is low and clears on reset.
module ram_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/acc_datapath.sv
// Datapath behind the adder FSM: operand/result RAM, sticky-overflow
// accumulator, saturating load counter and a valid/ack result register.
module acc_datapath
    import acc_pkg::*;
#(
    parameter int DATA_W = ACC_DATA_W,
    parameter int ADDR_W = ACC_ADDR_W,
    parameter int DEPTH  = ACC_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              rden,
    input  logic              wren,
    input  logic              load,
    input  logic              transf,
    input  logic              clear,
    input  logic              ready,
    input  logic              pre_we,
    input  logic [ADDR_W-1:0] pre_addr,
    input  logic [DATA_W-1:0] pre_wdata,
    output logic [DATA_W-1:0] result,
    output logic              result_ovf,
    output logic              result_valid,
    input  logic              result_ack,
    output logic [ADDR_W:0]   sum_count
);

    localparam logic [ADDR_W:0] COUNT_MAX = '1;

    logic [DATA_W-1:0] acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              result_ovf_q, result_ovf_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W:0]   sum;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    // Write-back from the FSM beats a simultaneous preload.
    assign ram_we    = wren | (pre_we & ready);
    assign ram_waddr = wren ? address  : pre_addr;
    assign ram_wdata = wren ? result_q : pre_wdata;

    ram_sync #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (reset),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .re      (rden),
        .raddr   (address),
        .rdata_o (mem_rdata)
    );

    assign sum = {1'b0, acc_q} + {1'b0, mem_rdata};

    always_comb begin
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        count_d      = count_q;
        result_d     = result_q;
        result_ovf_d = result_ovf_q;
        valid_d      = valid_q;

        if (clear) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
        end else if (load) begin
            acc_d   = sum[DATA_W-1:0];
            ovf_d   = ovf_q | sum[DATA_W];
            count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
        end

        // Transfer samples the pre-edge accumulator and wins over an ack.
        if (transf) begin
            result_d     = acc_q;
            result_ovf_d = ovf_q;
            valid_d      = 1'b1;
        end else if (result_ack) begin
            valid_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            count_q      <= '0;
            result_q     <= '0;
            result_ovf_q <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            count_q      <= count_d;
            result_q     <= result_d;
            result_ovf_q <= result_ovf_d;
            valid_q      <= valid_d;
        end
    end

    assign result       = result_q;
    assign result_ovf   = result_ovf_q;
    assign result_valid = valid_q;
    assign sum_count    = count_q;

endmodule

// File: tb/tb_acc_datapath.sv
// Self-checking bench for acc_datapath: directed scenarios followed by
// random strobes, all compared each cycle against a behavioural model.
module tb_acc_datapath;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int NW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address;
    logic          rden, wren, load, transf, clear, ready;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_wdata;
    logic [DW-1:0] result;
    logic          result_ovf, result_valid, result_ack;
    logic [AW:0]   sum_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, plain integers
    int m_ram [NW];
    int m_mem, m_acc, m_ovf, m_cnt, m_res, m_rovf, m_val;
    int init_val [NW];

    always #5 clk = ~clk;

    acc_datapath dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .rden         (rden),
        .wren         (wren),
        .load         (load),
        .transf       (transf),
        .clear        (clear),
        .ready        (ready),
        .pre_we       (pre_we),
        .pre_addr     (pre_addr),
        .pre_wdata    (pre_wdata),
        .result       (result),
        .result_ovf   (result_ovf),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .sum_count    (sum_count)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        address = '0; rden = 0; wren = 0; load = 0; transf = 0; clear = 0;
        pre_we = 0; pre_addr = '0; pre_wdata = '0; result_ack = 0;
    endtask

    task automatic model_reset();
        m_mem = 0; m_acc = 0; m_ovf = 0; m_cnt = 0; m_res = 0; m_rovf = 0; m_val = 0;
    endtask

    task automatic model_step();
        int o_mem, o_acc, o_ovf, o_res, s;
        o_mem = m_mem; o_acc = m_acc; o_ovf = m_ovf; o_res = m_res;
        if (rden) m_mem = m_ram[address];
        if (wren) m_ram[address] = o_res;
        else if (pre_we && ready) m_ram[pre_addr] = int'(pre_wdata);
        if (clear) begin
            m_acc = 0; m_ovf = 0; m_cnt = 0;
        end else if (load) begin
            s     = o_acc + o_mem;
            m_acc = s % 256;
            m_ovf = (o_ovf != 0 || s > 255) ? 1 : 0;
            m_cnt = (m_cnt < 63) ? m_cnt + 1 : 63;
        end
        if (transf) begin
            m_res = o_acc; m_rovf = o_ovf; m_val = 1;
        end else if (result_ack) begin
            m_val = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".result"}, int'(result), m_res);
        check({tag, ".ovf"},    int'(result_ovf), m_rovf);
        check({tag, ".valid"},  int'(result_valid), m_val);
        check({tag, ".count"},  int'(sum_count), m_cnt);
    endtask

    // One clock: model follows the edge, outputs sampled 1ns later.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
        idle();
    endtask

    task automatic preload(input int a, input int d);
        ready = 1; pre_we = 1; pre_addr = AW'(a); pre_wdata = DW'(d);
        cyc("preload");
    endtask

    // Clear, read one word, accumulate it and transfer: result shows RAM[a].
    task automatic read_word(input int a);
        clear = 1; rden = 1; address = AW'(a); cyc("rd_rden");
        load = 1;  cyc("rd_load");
        transf = 1; cyc("rd_transf");
    endtask

    task automatic sum_two(input int a, input int b);
        clear = 1; cyc("sum_clr");
        rden = 1; address = AW'(a); cyc("sum_rd0");
        rden = 1; address = AW'(b); load = 1; cyc("sum_rd1");
        load = 1; cyc("sum_ld1");
        transf = 1; cyc("sum_xf");
    endtask

    initial begin
        idle();
        ready = 1;
        reset = 1;
        model_reset();
        #12;
        check("rst.result", int'(result), 0);
        check("rst.ovf",    int'(result_ovf), 0);
        check("rst.valid",  int'(result_valid), 0);
        check("rst.count",  int'(sum_count), 0);
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < NW; i++) init_val[i] = int'($urandom_range(0, 255));
        init_val[0] = 3; init_val[1] = 5; init_val[2] = 200; init_val[3] = 100;
        for (int i = 0; i < NW; i++) begin
            m_ram[i] = init_val[i];
            preload(i, init_val[i]);
        end

        // Preload and accumulate
        sum_two(0, 1);
        check("acc.result", int'(result), 8);
        check("acc.ovf",    int'(result_ovf), 0);
        check("acc.count",  int'(sum_count), 2);
        check("acc.valid",  int'(result_valid), 1);

        // Overflow, then clear keeps captured flag
        sum_two(2, 3);
        check("ovf.result", int'(result), 44);
        check("ovf.flag",   int'(result_ovf), 1);
        clear = 1; cyc("ovf_clr");
        check("ovf.keep",   int'(result_ovf), 1);
        check("ovf.count0", int'(sum_count), 0);
        transf = 1; cyc("ovf_xf0");
        check("ovf.newres", int'(result), 0);
        check("ovf.newflag", int'(result_ovf), 0);

        // Write-back and read-first collision
        sum_two(0, 1);
        wren = 1; address = 5'd5; cyc("wb_wren");
        read_word(5);
        check("wb.readback", int'(result), 8);
        preload(6, 9);
        read_word(6);
        check("wb.res9", int'(result), 9);
        clear = 1; rden = 1; wren = 1; address = 5'd5; cyc("rf_coll");
        load = 1; cyc("rf_load");
        transf = 1; cyc("rf_xf");
        check("rf.oldword", int'(result), 8);
        read_word(5);
        check("rf.newword", int'(result), 9);

        // Preload gating by ready
        ready = 0; pre_we = 1; pre_addr = 5'd7; pre_wdata = DW'(init_val[7] ^ 8'h5A);
        cyc("gate_pre");
        ready = 1;
        read_word(7);
        check("gate.ram7", int'(result), init_val[7]);

        // Write port priority: wren beats preload
        pre_we = 1; pre_addr = 5'd4; pre_wdata = ~result; wren = 1; address = 5'd4;
        cyc("prio_wr");
        read_word(4);
        check("prio.ram4", int'(result), init_val[7]);

        // Handshake
        result_ack = 1; cyc("hs_ack");
        check("hs.dropped", int'(result_valid), 0);
        result_ack = 1; cyc("hs_ack_idle");
        check("hs.ack_idle", int'(result_valid), 0);
        transf = 1; cyc("hs_xf");
        check("hs.valid", int'(result_valid), 1);
        transf = 1; result_ack = 1; cyc("hs_xf_ack");
        check("hs.xf_ack", int'(result_valid), 1);

        // Reset between a load and its transfer
        clear = 1; rden = 1; address = 5'd1; cyc("mr_rd");
        load = 1; cyc("mr_load");
        #2 reset = 1;
        #1;
        model_reset();
        check("mr.result", int'(result), 0);
        check("mr.ovf",    int'(result_ovf), 0);
        check("mr.valid",  int'(result_valid), 0);
        check("mr.count",  int'(sum_count), 0);
        @(negedge clk);
        reset = 0;
        read_word(1);
        check("mr.ramkept", int'(result), 5);

        // Random strobes against the model
        for (int n = 0; n < 600; n++) begin
            address    = AW'($urandom_range(0, NW - 1));
            rden       = ($urandom_range(0, 1) == 1);
            wren       = ($urandom_range(0, 9) == 0);
            load       = ($urandom_range(0, 9) < 4);
            clear      = ($urandom_range(0, 19) == 0);
            transf     = ($urandom_range(0, 6) == 0);
            result_ack = ($urandom_range(0, 4) == 0);
            ready      = ($urandom_range(0, 1) == 1);
            pre_we     = ($urandom_range(0, 4) == 0);
            pre_addr   = AW'($urandom_range(0, NW - 1));
            pre_wdata  = DW'($urandom_range(0, 255));
            cyc("rand");
        end
        ready = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_datapath.md
Name: acc_datapath

Overview:
- Datapath stage directly downstream of the adder control FSM.
- Consumes the FSM strobes (address, rden, wren, load, transf, clear, ready).
- Holds the 32-word operand/result RAM, the accumulator, the sticky overflow flag and the output result register with a valid/ack handshake.
- Exposes a preload port so memory is filled only while the FSM reports ready.

Parameters:
- DATA_W, 8: operand/accumulator width in bits.
- ADDR_W, 5: RAM address width. Must match the FSM address port.
- DEPTH, 32: RAM words. Equals 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all registers; RAM contents not cleared.
- address  in  ADDR_W  RAM address from FSM.
- rden  in  1  RAM read strobe from FSM.
- wren  in  1  RAM write strobe from FSM; writes result register data.
- load  in  1  accumulate strobe: acc += RAM read data.
- transf  in  1  transfer acc/overflow to result register.
- clear  in  1  zero acc, overflow, count.
- ready  in  1  FSM idle indicator; gates preload port.
- pre_we  in  1  preload write enable.
- pre_addr  in  ADDR_W  preload address.
- pre_wdata  in  DATA_W  preload data.
- result  out  DATA_W  transferred sum.
- result_ovf  out  1  overflow flag captured with result.
- result_valid  out  1  result held and not yet acknowledged.
- result_ack  in  1  consumer acknowledge.
- sum_count  out  ADDR_W+1  number of loads since last clear, saturating.

Behaviour:
- Reset values: acc=0, ovf=0, sum_count=0, result=0, result_ovf=0, result_valid=0, mem_q=0.
- RAM read (sync, latency 1): rden at edge t puts RAM[address] into mem_q at t+1. mem_q holds while rden=0.
- Read/write collision: rden and wren in the same cycle at the same address is read-first; mem_q gets the old word.
- RAM write: on wren, RAM[address] <= result.
- Preload: on pre_we with ready=1, RAM[pre_addr] <= pre_wdata. Ignored when ready=0.
- Write port priority: if wren and pre_we both qualify in the same cycle, wren wins and the preload is dropped.
- Accumulate: on load, {carry, acc} <= acc + mem_q, computed at DATA_W+1 bits. acc takes the low DATA_W bits (wraps modulo 2**DATA_W). ovf <= ovf | carry (sticky). sum_count increments and saturates at 2**(ADDR_W+1)-1.
- The FSM must assert load at least one cycle after the matching rden. Load uses whatever mem_q currently holds; the datapath does no latency checking.
- Clear: acc, ovf and sum_count go to 0. clear has priority over load in the same cycle (load ignored).
- Transfer: on transf, result <= acc and result_ovf <= ovf, using pre-edge values. If load is active in the same cycle, the pre-load acc is transferred. result_valid <= 1.
- Handshake:
  - result_valid stays 1 until the result_ack edge, then drops next cycle.
  - transf with result_ack in the same cycle: new result loaded, result_valid stays 1.
  - transf while valid and unacked: result is overwritten, valid stays 1. No stall; the FSM owns pacing.
  - result_ack while valid=0 has no effect.
- Reset mid-operation: all registers clear asynchronously. In-flight reads and writes are abandoned; RAM retains its data.
- Outputs are driven straight from registers; no combinational input-to-output paths.

Decomposition:
- Shared package acc_pkg holds DATA_W, ADDR_W and DEPTH defaults, shared with the FSM so address widths agree.
- One sub-module, ram_sync: single-port-write, read-first synchronous RAM with 1-cycle read latency, parameterised by DATA_W and ADDR_W.
- Preload muxing, accumulator, count and handshake logic stay in acc_datapath.

Test Plan:
- Preload and accumulate: ready=1; preload RAM[0]=3, RAM[1]=5. rden@0, load, rden@1, load, transf -> result=8, result_ovf=0, sum_count=2, result_valid=1.
- Overflow: RAM[2]=200, RAM[3]=100; clear, accumulate both, transf -> result=44, result_ovf=1. Then clear -> acc=0, ovf=0, count=0; result_ovf stays 1 until the next transf.
- Write-back and read-first: transf result=8; wren@5 -> read back RAM[5]=8. Then pre-set RAM[5]=8, result=9, rden+wren@5 in one cycle -> mem_q=8 next cycle, later read returns 9.
- Preload gating and priority:
  - pre_we with ready=0 to addr 7 -> RAM[7] unchanged.
  - wren and pre_we together, both to addr 4 -> RAM[4]=result.
- Handshake:
  - transf -> valid=1; ack -> valid=0 next cycle.
  - transf and ack in the same cycle -> valid stays 1 with the new result.
  - ack with valid=0 -> no change.
- Reset mid-run: assert reset between a load and its transf -> all outputs 0 immediately (asynchronous). After release, the RAM preload data is still readable.
